// File: rtl/ray_stepper.sv
// rtl/ray_stepper.sv - sequential two-axis grid march for one ray with nearest-hit distance
module ray_stepper #(
    parameter int MAP_X      = 8,
    parameter int MAP_Y      = 8,
    parameter int CELL_SHIFT = 22,
    parameter int MAX_STEPS  = 8
) (
    input  logic                     clk_in,
    input  logic                     rst_in,
    input  logic                     req_valid_in,
    output logic                     req_ready_out,
    input  logic [9:0]               req_col_in,
    input  logic [63:0]              req_origin_in,
    input  logic [63:0]              req_h_pos_in,
    input  logic [63:0]              req_h_step_in,
    input  logic                     req_h_en_in,
    input  logic [63:0]              req_v_pos_in,
    input  logic [63:0]              req_v_step_in,
    input  logic                     req_v_en_in,
    output logic [$clog2(MAP_X)-1:0] hmap_x_out,
    output logic [$clog2(MAP_Y)-1:0] hmap_y_out,
    input  logic                     hmap_wall_in,
    output logic [$clog2(MAP_X)-1:0] vmap_x_out,
    output logic [$clog2(MAP_Y)-1:0] vmap_y_out,
    input  logic                     vmap_wall_in,
    output logic                     res_valid_out,
    input  logic                     res_ready_in,
    output logic [9:0]               res_col_out,
    output logic                     res_is_vert_out,
    output logic                     res_miss_out,
    output logic [31:0]              res_sqdist_out
);
    localparam int XW = $clog2(MAP_X);
    localparam int YW = $clog2(MAP_Y);
    localparam int CW = (MAX_STEPS > 1) ? $clog2(MAX_STEPS) : 1;
    localparam logic [31:0] SAT = 32'h7FFF_FFFF;

    typedef enum logic [2:0] {IDLE, ADDR, CHECK, DIST_H, DIST_V, DONE} state_t;

    state_t        state;
    logic [31:0]   org_x, org_y;
    logic [31:0]   h_x, h_y, h_dx, h_dy;
    logic [31:0]   v_x, v_y, v_dx, v_dy;
    logic          h_done, v_done, h_hit, v_hit;
    logic [CW-1:0] cnt;
    logic [31:0]   h_sq;

    // A position is off the map when negative or past the last cell on either component
    function automatic logic off_map(input logic [31:0] px, input logic [31:0] py);
        logic [31:0] cx, cy;
        cx = px >> CELL_SHIFT;
        cy = py >> CELL_SHIFT;
        return px[31] | py[31] | (cx >= 32'(MAP_X)) | (cy >= 32'(MAP_Y));
    endfunction

    // Map addresses follow the live positions so the wall bit is ready by CHECK
    assign hmap_x_out = h_x[CELL_SHIFT+XW-1:CELL_SHIFT];
    assign hmap_y_out = h_y[CELL_SHIFT+YW-1:CELL_SHIFT];
    assign vmap_x_out = v_x[CELL_SHIFT+XW-1:CELL_SHIFT];
    assign vmap_y_out = v_y[CELL_SHIFT+YW-1:CELL_SHIFT];

    assign req_ready_out = (state == IDLE) && rst_in;

    logic last_step;
    logic h_done_nx, h_hit_nx, h_adv;
    logic v_done_nx, v_hit_nx, v_adv;

    // Per-axis march decision for the current CHECK cycle
    always_comb begin
        last_step = (cnt == CW'(MAX_STEPS - 1));
        h_done_nx = h_done;
        h_hit_nx  = h_hit;
        h_adv     = 1'b0;
        v_done_nx = v_done;
        v_hit_nx  = v_hit;
        v_adv     = 1'b0;
        if (!h_done) begin
            if (off_map(h_x, h_y))  h_done_nx = 1'b1;
            else if (hmap_wall_in) begin h_done_nx = 1'b1; h_hit_nx = 1'b1; end
            else if (last_step)     h_done_nx = 1'b1;
            else                    h_adv     = 1'b1;
        end
        if (!v_done) begin
            if (off_map(v_x, v_y))  v_done_nx = 1'b1;
            else if (vmap_wall_in) begin v_done_nx = 1'b1; v_hit_nx = 1'b1; end
            else if (last_step)     v_done_nx = 1'b1;
            else                    v_adv     = 1'b1;
        end
    end

    logic [31:0]        sq_px, sq_py;
    logic signed [32:0] dx, dy;
    logic signed [65:0] dx_e, dy_e, dx2, dy2;
    logic [66:0]        sq_sum;
    logic [34:0]        sq_hi;
    logic [31:0]        sq_val;

    // Shared squarer: horizontal hit in DIST_H, vertical hit otherwise
    always_comb begin
        sq_px  = (state == DIST_H) ? h_x : v_x;
        sq_py  = (state == DIST_H) ? h_y : v_y;
        dx     = $signed({sq_px[31], sq_px}) - $signed({org_x[31], org_x});
        dy     = $signed({sq_py[31], sq_py}) - $signed({org_y[31], org_y});
        dx_e   = 66'(dx);
        dy_e   = 66'(dy);
        dx2    = dx_e * dx_e;
        dy2    = dy_e * dy_e;
        sq_sum = {1'b0, dx2} + {1'b0, dy2};
        sq_hi  = sq_sum[66:32];
        sq_val = (sq_hi > 35'(SAT)) ? SAT : sq_hi[31:0];
    end

    logic [31:0] h_eff, v_eff;
    logic        sel_vert, sel_miss;

    // Nearest-hit selection; equal distances resolve to the horizontal hit
    always_comb begin
        h_eff    = h_hit ? h_sq : SAT;
        v_eff    = v_hit ? sq_val : SAT;
        sel_miss = !h_hit && !v_hit;
        sel_vert = v_hit && (!h_hit || (v_eff < h_eff));
    end

    // Control FSM: latch request, march both axes, measure, then hand off the result
    always_ff @(posedge clk_in or negedge rst_in) begin
        if (!rst_in) begin
            state           <= IDLE;
            org_x           <= '0;
            org_y           <= '0;
            h_x             <= '0;
            h_y             <= '0;
            h_dx            <= '0;
            h_dy            <= '0;
            v_x             <= '0;
            v_y             <= '0;
            v_dx            <= '0;
            v_dy            <= '0;
            h_done          <= 1'b0;
            v_done          <= 1'b0;
            h_hit           <= 1'b0;
            v_hit           <= 1'b0;
            cnt             <= '0;
            h_sq            <= '0;
            res_valid_out   <= 1'b0;
            res_col_out     <= '0;
            res_is_vert_out <= 1'b0;
            res_miss_out    <= 1'b0;
            res_sqdist_out  <= '0;
        end else begin
            case (state)
                IDLE: if (req_valid_in) begin
                    res_col_out <= req_col_in;
                    {org_x, org_y} <= req_origin_in;
                    {h_x, h_y}     <= req_h_pos_in;
                    {h_dx, h_dy}   <= req_h_step_in;
                    {v_x, v_y}     <= req_v_pos_in;
                    {v_dx, v_dy}   <= req_v_step_in;
                    h_done <= !req_h_en_in;
                    v_done <= !req_v_en_in;
                    h_hit  <= 1'b0;
                    v_hit  <= 1'b0;
                    cnt    <= '0;
                    state  <= ADDR;
                end
                ADDR: state <= CHECK;
                CHECK: begin
                    h_done <= h_done_nx;
                    h_hit  <= h_hit_nx;
                    v_done <= v_done_nx;
                    v_hit  <= v_hit_nx;
                    if (h_adv) begin h_x <= h_x + h_dx; h_y <= h_y + h_dy; end
                    if (v_adv) begin v_x <= v_x + v_dx; v_y <= v_y + v_dy; end
                    if (h_done_nx && v_done_nx) begin
                        state <= DIST_H;
                    end else begin
                        cnt   <= cnt + 1'b1;
                        state <= ADDR;
                    end
                end
                DIST_H: begin
                    h_sq  <= sq_val;
                    state <= DIST_V;
                end
                DIST_V: begin
                    res_miss_out    <= sel_miss;
                    res_is_vert_out <= sel_vert;
                    res_sqdist_out  <= sel_miss ? SAT : (sel_vert ? v_eff : h_eff);
                    state           <= DONE;
                end
                DONE: begin
                    // Result registers settle for one cycle before valid is raised
                    if (!res_valid_out) begin
                        res_valid_out <= 1'b1;
                    end else if (res_ready_in) begin
                        res_valid_out <= 1'b0;
                        state         <= IDLE;
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end
endmodule

// File: tb/tb_ray_stepper.sv
// tb/tb_ray_stepper.sv - directed self-checking bench for ray_stepper
module tb_ray_stepper;
    logic        clk_in = 1'b0;
    logic        rst_in = 1'b0;
    logic        req_valid_in = 1'b0;
    logic        req_ready_out;
    logic [9:0]  req_col_in = '0;
    logic [63:0] req_origin_in = '0;
    logic [63:0] req_h_pos_in = '0;
    logic [63:0] req_h_step_in = '0;
    logic        req_h_en_in = 1'b0;
    logic [63:0] req_v_pos_in = '0;
    logic [63:0] req_v_step_in = '0;
    logic        req_v_en_in = 1'b0;
    logic [2:0]  hmap_x_out, hmap_y_out, vmap_x_out, vmap_y_out;
    logic        hmap_wall_in = 1'b0;
    logic        vmap_wall_in = 1'b0;
    logic        res_valid_out;
    logic        res_ready_in = 1'b0;
    logic [9:0]  res_col_out;
    logic        res_is_vert_out;
    logic        res_miss_out;
    logic [31:0] res_sqdist_out;

    logic [63:0] wall_map = '0;
    int          checks = 0;
    int          errors = 0;

    ray_stepper dut (
        .clk_in(clk_in), .rst_in(rst_in),
        .req_valid_in(req_valid_in), .req_ready_out(req_ready_out),
        .req_col_in(req_col_in), .req_origin_in(req_origin_in),
        .req_h_pos_in(req_h_pos_in), .req_h_step_in(req_h_step_in), .req_h_en_in(req_h_en_in),
        .req_v_pos_in(req_v_pos_in), .req_v_step_in(req_v_step_in), .req_v_en_in(req_v_en_in),
        .hmap_x_out(hmap_x_out), .hmap_y_out(hmap_y_out), .hmap_wall_in(hmap_wall_in),
        .vmap_x_out(vmap_x_out), .vmap_y_out(vmap_y_out), .vmap_wall_in(vmap_wall_in),
        .res_valid_out(res_valid_out), .res_ready_in(res_ready_in),
        .res_col_out(res_col_out), .res_is_vert_out(res_is_vert_out),
        .res_miss_out(res_miss_out), .res_sqdist_out(res_sqdist_out)
    );

    always #5 clk_in = ~clk_in;

    // Synchronous-read wall map: bit index = row*8 + column
    always @(posedge clk_in) begin
        hmap_wall_in <= wall_map[{hmap_y_out, hmap_x_out}];
        vmap_wall_in <= wall_map[{vmap_y_out, vmap_x_out}];
    end

    function automatic logic [63:0] xy(input int x, input int y);
        logic [31:0] a, b;
        a = 32'(x * 65536);
        b = 32'(y * 65536);
        return {a, b};
    endfunction

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: got 0x%0h expected 0x%0h", tag, obs, exp);
        end
    endtask

    task automatic run_ray(input string tag, input int lat, input logic ev, input logic em,
                           input logic [31:0] es, input int hold);
        int cyc;
        chk({tag, "_ready"}, 64'(req_ready_out), 64'd1);
        req_valid_in = 1'b1;
        @(posedge clk_in); #1;
        req_valid_in = 1'b0;
        cyc = 0;
        while (!res_valid_out && cyc < 40) begin
            @(posedge clk_in); #1;
            cyc++;
        end
        chk({tag, "_latency"}, 64'(cyc), 64'(lat));
        chk({tag, "_col"}, 64'(res_col_out), 64'(req_col_in));
        chk({tag, "_is_vert"}, 64'(res_is_vert_out), 64'(ev));
        chk({tag, "_miss"}, 64'(res_miss_out), 64'(em));
        chk({tag, "_sqdist"}, 64'(res_sqdist_out), 64'(es));
        for (int i = 0; i < hold; i++) begin
            @(posedge clk_in); #1;
            chk({tag, "_hold_valid"}, 64'(res_valid_out), 64'd1);
            chk({tag, "_hold_sqdist"}, 64'(res_sqdist_out), 64'(es));
            chk({tag, "_hold_is_vert"}, 64'(res_is_vert_out), 64'(ev));
            chk({tag, "_hold_col"}, 64'(res_col_out), 64'(req_col_in));
            chk({tag, "_hold_req_ready"}, 64'(req_ready_out), 64'd0);
        end
        res_ready_in = 1'b1;
        @(posedge clk_in); #1;
        res_ready_in = 1'b0;
        chk({tag, "_valid_drop"}, 64'(res_valid_out), 64'd0);
        chk({tag, "_idle_ready"}, 64'(req_ready_out), 64'd1);
    endtask

    initial begin
        // Reset state
        #12;
        chk("rst_req_ready", 64'(req_ready_out), 64'd0);
        chk("rst_res_valid", 64'(res_valid_out), 64'd0);
        chk("rst_addr", {52'd0, hmap_x_out, hmap_y_out, vmap_x_out, vmap_y_out}, 64'd0);
        rst_in = 1'b1;
        @(posedge clk_in); #1;
        chk("post_rst_ready", 64'(req_ready_out), 64'd1);

        // Vertical wall only, plus first address check
        wall_map = '0;
        wall_map[4*8+6] = 1'b1;
        req_origin_in = xy(256, 256);
        req_col_in    = 10'd17;
        req_h_en_in   = 1'b0;
        req_h_pos_in  = '0;
        req_h_step_in = '0;
        req_v_en_in   = 1'b1;
        req_v_pos_in  = xy(320, 256);
        req_v_step_in = xy(64, 0);
        run_ray("vwall", 7, 1'b1, 1'b0, 32'h4000, 0);

        // Equal-distance hits on both axes resolve horizontal
        wall_map[6*8+4] = 1'b1;
        req_col_in    = 10'd300;
        req_h_en_in   = 1'b1;
        req_h_pos_in  = xy(256, 320);
        req_h_step_in = xy(0, 64);
        run_ray("tie", 7, 1'b0, 1'b0, 32'h4000, 0);

        // Horizontal nearer: vertical wall moved to column 7 (distance 192 -> 0x9000)
        wall_map[4*8+6] = 1'b0;
        wall_map[4*8+7] = 1'b1;
        req_col_in = 10'd5;
        run_ray("hnear", 9, 1'b0, 1'b0, 32'h4000, 0);

        // Vertical alone against column 7 wall gives the 192-unit distance
        req_h_en_in = 1'b0;
        run_ray("vfar", 9, 1'b1, 1'b0, 32'h9000, 0);

        // Empty map, ray exits at x=512
        wall_map = '0;
        req_col_in = 10'd1023;
        run_ray("exit", 11, 1'b0, 1'b1, 32'h7FFF_FFFF, 0);

        // Ray walks to negative x and leaves the map
        req_v_pos_in  = xy(192, 256);
        req_v_step_in = xy(-64, 0);
        run_ray("negexit", 13, 1'b0, 1'b1, 32'h7FFF_FFFF, 0);

        // Zero step never leaves the cell: step budget exhausted
        req_v_pos_in  = xy(320, 256);
        req_v_step_in = xy(0, 0);
        run_ray("maxsteps", 19, 1'b0, 1'b1, 32'h7FFF_FFFF, 0);

        // Result backpressure for 5 cycles
        wall_map[4*8+6] = 1'b1;
        req_v_step_in = xy(64, 0);
        req_col_in = 10'd42;
        run_ray("bp", 7, 1'b1, 1'b0, 32'h4000, 5);

        // Reset asserted during CHECK aborts the ray
        req_valid_in = 1'b1;
        @(posedge clk_in); #1;
        req_valid_in = 1'b0;
        chk("addr_vx", 64'(vmap_x_out), 64'd5);
        chk("addr_vy", 64'(vmap_y_out), 64'd4);
        @(posedge clk_in); #2;
        rst_in = 1'b0;
        #1;
        chk("abort_valid", 64'(res_valid_out), 64'd0);
        chk("abort_ready", 64'(req_ready_out), 64'd0);
        @(negedge clk_in);
        rst_in = 1'b1;
        @(posedge clk_in); #1;
        chk("abort_release_ready", 64'(req_ready_out), 64'd1);
        run_ray("rerun", 7, 1'b1, 1'b0, 32'h4000, 0);

        // Both axes disabled
        req_h_en_in = 1'b0;
        req_v_en_in = 1'b0;
        run_ray("noaxis", 5, 1'b0, 1'b1, 32'h7FFF_FFFF, 0);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule

// File: doc/ray_stepper.md
Name: ray_stepper

Overview:
- Sequential grid-march engine for one ray (one screen column).
- Upstream of the column line buffer and renderer; replaces the single-cycle unrolled cast.
- Takes precomputed first horizontal- and vertical-gridline intersections plus per-step deltas, then walks both axes against the map.
- Returns the nearer wall hit as a truncated squared distance with an is_vert flag, via valid/ready handshakes.

Parameters:
MAP_X, 8, map width in cells (power of two)
MAP_Y, 8, map height in cells (power of two)
CELL_SHIFT, 22, log2 of cell size in Q16.16 (64 units)
MAX_STEPS, 8, maximum intersections checked per axis

Ports:
clk_in  input  1  pixel clock
rst_in  input  1  reset; asynchronous, active-low
req_valid_in  input  1  request valid
req_ready_out  output  1  high only in IDLE with reset released
req_col_in  input  10  column tag, returned unchanged
req_origin_in  input  64  player position {x[63:32], y[31:0]}, Q16.16 signed
req_h_pos_in  input  64  first horizontal-line intersection {x,y}
req_h_step_in  input  64  horizontal-line step {dx,dy}
req_h_en_in  input  1  horizontal axis enabled (0 = ray parallel to it)
req_v_pos_in  input  64  first vertical-line intersection {x,y}
req_v_step_in  input  64  vertical-line step {dx,dy}
req_v_en_in  input  1  vertical axis enabled
hmap_x_out  output  log2(MAP_X)  horizontal-axis map read column
hmap_y_out  output  log2(MAP_Y)  horizontal-axis map read row
hmap_wall_in  input  1  wall bit; valid one cycle after address
vmap_x_out  output  log2(MAP_X)  vertical-axis map read column
vmap_y_out  output  log2(MAP_Y)  vertical-axis map read row
vmap_wall_in  input  1  wall bit; valid one cycle after address
res_valid_out  output  1  result valid
res_ready_in  input  1  consumer accepts result
res_col_out  output  10  column tag
res_is_vert_out  output  1  nearer hit is on a vertical gridline
res_miss_out  output  1  neither axis hit a wall
res_sqdist_out  output  32  (dx²+dy²)>>32 of the chosen hit

Behaviour:
- Reset (rst_in low, asynchronous):
  - state = IDLE; all registered outputs = 0.
  - req_ready_out = 0 while reset is asserted.
  - Map address outputs = 0.
- States: IDLE, ADDR, CHECK, DIST_H, DIST_V, DONE.
- IDLE:
  - req_ready_out = 1.
  - On req_valid_in & req_ready_out: latch all request fields; set step count = 0; set each axis done flag = !en; go to ADDR.
- ADDR:
  - Drive map addresses from the current positions: cell = pos[CELL_SHIFT+log2(N)-1 : CELL_SHIFT].
  - Go to CHECK.
- CHECK, per axis not yet done:
  - Out-of-map (pos bit 31 set, or pos[31:CELL_SHIFT] ≥ MAP_X for x / ≥ MAP_Y for y) → done, miss. The wall bit is ignored.
  - Else wall = 1 → done, hit; latch pos.
  - Else step count = MAX_STEPS-1 → done, miss.
  - Else pos += step (32-bit wrap per component).
  - Then: if both axes are done → DIST_H; else increment step count, go to ADDR.
- Both axes disabled: one ADDR/CHECK pair is still executed, then DIST_H.
- DIST_H / DIST_V:
  - One shared squarer pair.
  - dx, dy = 33-bit signed differences of hit pos and origin.
  - sq = (dx²+dy²)>>32, saturated to 32'h7FFFFFFF.
  - A missed axis has sq = 32'h7FFFFFFF.
- Select, registered on leaving DIST_V:
  - is_vert = v_hit & (!h_hit | v_sq < h_sq). A tie resolves to horizontal.
  - miss = !h_hit & !v_hit. On a miss: sqdist = 32'h7FFFFFFF, is_vert = 0.
- DONE:
  - res_valid_out = 1; all res_* held stable until res_ready_in is sampled high.
  - Then res_valid_out = 0, go to IDLE.
  - No new request is accepted before that edge.
- Latency: res_valid_out rises 2S+3 cycles after the accepting edge, where S = number of CHECK cycles (1 ≤ S ≤ MAX_STEPS).
- Throughput: one ray in flight.
- Reset mid-operation: abort immediately, discard latched state; the next request after release is processed normally.

Test Plan:
- Vertical wall only:
  - Stimulus: origin (256,256); map wall at cell (6,4); v_pos (320,256), v_step (64,0); h disabled.
  - Required: S=2, res_valid at +7 cycles, is_vert=1, miss=0, sqdist=0x4000.
- Equal-distance hits:
  - Stimulus: both axes hit at distance 128, symmetric geometry.
  - Required: is_vert=0, sqdist=0x4000.
- Empty map, ray leaves map:
  - Stimulus: v_pos (320,256), v_step (64,0); h disabled.
  - Required: out-of-map at 512, S=4, latency 11, miss=1, sqdist=0x7FFFFFFF, is_vert=0.
- Result backpressure:
  - Stimulus: hold res_ready_in low for 5 cycles in DONE.
  - Required: res_* stable, req_ready_out=0 throughout; IDLE one cycle after ready is sampled.
- Reset mid-march:
  - Stimulus: assert rst_in low during CHECK.
  - Required: res_valid_out=0 asynchronously; after release req_ready_out=1, and a repeat of the first scenario yields an identical result.
- Both axes disabled:
  - Stimulus: req_h_en_in = req_v_en_in = 0.
  - Required: S=1, latency 5, miss=1.
